fn_sw_unit: RTL and testbench
=============================

Name: fn_sw_unit

Overview:
- Registered, handshaked bitwise function-switch unit.
- Each accepted operand pair (a, b) yields AND when sel=1 and XOR when sel=0.
- Results queue in a 2-entry output buffer and carry zero and parity flags.
- Sits between a valid/ready producer and a valid/ready consumer in the datapath.

Parameters:
WIDTH, 8, operand and result bit width (must be >= 1)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
in_valid  input  1  producer presents a valid operand set
in_ready  output  1  unit can accept an operand set this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  1  function select: 1 = a AND b, 0 = a XOR b
out_valid  output  1  out_y and the flags hold a valid result
out_ready  input  1  consumer accepts the current result
out_y  output  WIDTH  result at the head of the buffer
out_zero  output  1  1 when out_y is all zeros
out_parity  output  1  XOR-reduction of out_y

Behaviour:
- Function: y = sel ? (a & b) : (a ^ b), evaluated bitwise across WIDTH. sel is sampled with a and b in the accept cycle; it is never sampled later.
- Accept: an operand set is accepted on a rising clk edge where in_valid=1 and in_ready=1. The result and its zero/parity flags are computed combinationally and written into the buffer on that edge.
- Buffer: 2-entry FIFO with a count of 0..2.
  - in_ready = (count < 2). It is driven from registered state only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_y, out_zero and out_parity always show the head entry.
- Pop: occurs on an edge where out_valid=1 and out_ready=1.
- Latency: a result accepted at edge N is visible at the outputs after edge N when the buffer was empty. With a non-stalled consumer, throughput is one result per cycle.
- Simultaneous push and pop:
  - count 1: count stays 1, the head advances to the new result.
  - count 2: push is impossible (in_ready=0). Pop only.
- Full: count=2 holds in_ready=0. Inputs are ignored regardless of in_valid.
- Empty: out_valid=0. out_y, out_zero and out_parity hold their last head value; the consumer must not interpret them.
- Stall: while out_valid=1 and out_ready=0, the head entry and flags stay stable.
- Reset (rst_n=0 at an edge):
  - count=0, so out_valid=0 and in_ready=1 after the edge.
  - Both buffer entries, out_y and out_parity are cleared to 0. out_zero is forced to 1, consistent with out_y=0.
  - Reset overrides any simultaneous accept or pop; results in flight are discarded.
- Pointer wrap: read and write pointers are 1 bit and wrap 1 -> 0. Order is strictly FIFO.
- No X propagation: all state has a reset value.

Test Plan:
- Reset then idle, WIDTH=8: hold rst_n=0 for 2 cycles -> out_valid=0, in_ready=1, out_y=0x00, out_zero=1, out_parity=0.
- Single-bit basic truth cases, WIDTH=1, out_ready=1:
  - a=0, b=0, sel=0 -> out_y=0, out_zero=1.
  - a=0, b=0, sel=1 -> out_y=0, out_zero=1.
  - a=0, b=1, sel=0 -> out_y=1, out_parity=1.
  - Each result appears one cycle after its accept.
- Both functions, WIDTH=8, a=0xF0, b=0x3C:
  - sel=1 -> out_y=0x30, out_parity=0, out_zero=0.
  - sel=0 -> out_y=0xCC, out_parity=0.
  - a=0x01, b=0x00, sel=0 -> out_y=0x01, out_parity=1.
- Backpressure: out_ready=0, push 0xAA^0x55 (=0xFF) then 0x0F&0x0F (=0x0F).
  - After the 2nd accept, in_ready=0; a 3rd in_valid is ignored.
  - Raise out_ready: outputs 0xFF then 0x0F, in order, and in_ready returns to 1.
- Simultaneous push/pop at count=1: continuous in_valid=1 and out_ready=1 over 4 operand sets -> one result per cycle, in order, count never exceeds 1.
- Reset mid-operation: buffer holding 2 entries, assert rst_n=0 for one cycle -> out_valid=0, buffer empty; the next accepted a=0x12, b=0x10, sel=1 gives out_y=0x10.

Source files
------------

// File: rtl/fn_sw_unit.sv
// fn_sw_unit: registered, handshaked bitwise function-switch unit.
//
// Each accepted operand pair (a, b) produces y = sel ? (a & b) : (a ^ b).
// The result and its zero/parity flags are queued in a 2-entry FIFO. The
// head entry is presented on the output side.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   producer presents an operand set
//   in_ready   unit can accept an operand set (registered state only)
//   a, b       operands, WIDTH bits
//   sel        function select: 1 = AND, 0 = XOR
//   out_valid  head entry holds a valid result
//   out_ready  consumer accepts the head result
//   out_y      result at the head of the buffer
//   out_zero   1 when out_y is all zeros
//   out_parity XOR-reduction of out_y
module fn_sw_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity
);

    // Buffer storage: result plus its precomputed flags.
    logic [WIDTH-1:0] mem_y [2];
    logic             mem_z [2];
    logic             mem_p [2];

    logic [1:0]       cnt;
    logic             wptr;
    logic             rptr;

    // Head registers: these keep showing the last head after the buffer
    // drains, instead of exposing whichever stale slot rptr lands on.
    logic [WIDTH-1:0] head_y;
    logic             head_z;
    logic             head_p;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] res_y;
    logic             res_z;
    logic             res_p;
    logic [1:0]       cnt_nxt;
    logic             rptr_nxt;
    logic             fwd_new;

    assign in_ready   = (cnt != 2'd2);
    assign out_valid  = (cnt != 2'd0);
    assign out_y      = head_y;
    assign out_zero   = head_z;
    assign out_parity = head_p;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // NOTE: combinational logic uses blocking assignments with every output
    // given a default first, so no latch is inferred; the clocked block
    // below uses non-blocking assignments only.
    always_comb begin
        res_y    = sel ? (a & b) : (a ^ b);
        res_z    = ~|res_y;
        res_p    = ^res_y;
        rptr_nxt = rptr ^ pop;
        cnt_nxt  = cnt;
        unique case ({push, pop})
            2'b10:   cnt_nxt = cnt + 2'd1;
            2'b01:   cnt_nxt = cnt - 2'd1;
            default: cnt_nxt = cnt;
        endcase
        // The next head is the entry being written this edge when the write
        // slot coincides with the next read slot (empty push, or push+pop
        // at count 1); otherwise it is already in storage.
        fwd_new  = push && (wptr == rptr_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            // NOTE: the buffer storage is reset too, so no X can ever reach
            // the outputs; with two entries the cost is negligible.
            for (int i = 0; i < 2; i++) begin
                mem_y[i] <= '0;
                mem_z[i] <= 1'b1;
                mem_p[i] <= 1'b0;
            end
            head_y <= '0;
            head_z <= 1'b1;
            head_p <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            rptr <= rptr_nxt;
            if (push) begin
                mem_y[wptr] <= res_y;
                mem_z[wptr] <= res_z;
                mem_p[wptr] <= res_p;
                wptr        <= ~wptr;
            end
            if (cnt_nxt != 2'd0) begin
                if (fwd_new) begin
                    head_y <= res_y;
                    head_z <= res_z;
                    head_p <= res_p;
                end else begin
                    head_y <= mem_y[rptr_nxt];
                    head_z <= mem_z[rptr_nxt];
                    head_p <= mem_p[rptr_nxt];
                end
            end
        end
    end

endmodule

// File: tb/tb_fn_sw_unit.sv
// Directed self-checking bench for fn_sw_unit: an 8-bit and a 1-bit
// instance share clock and reset; each scenario task drives one of them.
module tb_fn_sw_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 8-bit instance
    logic       in_valid8, in_ready8, sel8, out_valid8, out_ready8;
    logic       out_zero8, out_parity8;
    logic [7:0] a8, b8, out_y8;

    // 1-bit instance
    logic       in_valid1, in_ready1, sel1, out_valid1, out_ready1;
    logic       out_zero1, out_parity1;
    logic [0:0] a1, b1, out_y1;

    fn_sw_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sel(sel8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_y(out_y8), .out_zero(out_zero8), .out_parity(out_parity8)
    );

    fn_sw_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sel(sel1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_y(out_y1), .out_zero(out_zero1), .out_parity(out_parity1)
    );

    // Advance one rising edge and settle; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sel8 = 1'b0; out_ready8 = 1'b0;
        in_valid1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  sel1 = 1'b0; out_ready1 = 1'b0;
        step();
        step();
        n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid8); end
        n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready8); end
        n_cmp++; if (out_y8 !== 8'h00) begin n_err++; $display("FAIL reset_out_y got %h want 00", out_y8); end
        n_cmp++; if (out_zero8 !== 1'b1) begin n_err++; $display("FAIL reset_out_zero got %b want 1", out_zero8); end
        n_cmp++; if (out_parity8 !== 1'b0) begin n_err++; $display("FAIL reset_out_parity got %b want 0", out_parity8); end
        n_cmp++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin n_err++; $display("FAIL reset_w1 got v=%b r=%b want v=0 r=1", out_valid1, in_ready1); end
        rst_n = 1'b1;
        step();
    endtask

    // Vectors: {a, b, sel, y, zero, parity}
    task automatic test_single_bit();
        logic [5:0] vec [5];
        vec[0] = 6'b0_0_0_0_1_0;
        vec[1] = 6'b0_0_1_0_1_0;
        vec[2] = 6'b0_1_0_1_0_1;
        vec[3] = 6'b1_1_1_1_0_1;
        vec[4] = 6'b1_1_0_0_1_0;
        out_ready1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid1 = 1'b1;
            a1 = vec[i][5]; b1 = vec[i][4]; sel1 = vec[i][3];
            step();
            n_cmp++;
            if (out_valid1 !== 1'b1 || out_y1 !== vec[i][2] || out_zero1 !== vec[i][1] || out_parity1 !== vec[i][0]) begin
                n_err++;
                $display("FAIL w1_vec%0d got v=%b y=%b z=%b p=%b want v=1 y=%b z=%b p=%b",
                         i, out_valid1, out_y1, out_zero1, out_parity1, vec[i][2], vec[i][1], vec[i][0]);
            end
        end
        in_valid1 = 1'b0;
        step();
        n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL w1_drain got v=%b want 0", out_valid1); end
    endtask

    task automatic test_functions();
        logic [7:0] va [5], vb [5], vy [5];
        logic       vs [5], vz [5], vp [5];
        va[0] = 8'hF0; vb[0] = 8'h3C; vs[0] = 1'b1; vy[0] = 8'h30; vz[0] = 1'b0; vp[0] = 1'b0;
        va[1] = 8'hF0; vb[1] = 8'h3C; vs[1] = 1'b0; vy[1] = 8'hCC; vz[1] = 1'b0; vp[1] = 1'b0;
        va[2] = 8'h01; vb[2] = 8'h00; vs[2] = 1'b0; vy[2] = 8'h01; vz[2] = 1'b0; vp[2] = 1'b1;
        va[3] = 8'h00; vb[3] = 8'hFF; vs[3] = 1'b1; vy[3] = 8'h00; vz[3] = 1'b1; vp[3] = 1'b0;
        va[4] = 8'hFE; vb[4] = 8'h7F; vs[4] = 1'b0; vy[4] = 8'h81; vz[4] = 1'b0; vp[4] = 1'b0;
        out_ready8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1; a8 = va[i]; b8 = vb[i]; sel8 = vs[i];
            step();
            in_valid8 = 1'b0;
            n_cmp++;
            if (out_valid8 !== 1'b1 || out_y8 !== vy[i] || out_zero8 !== vz[i] || out_parity8 !== vp[i]) begin
                n_err++;
                $display("FAIL func_vec%0d got v=%b y=%h z=%b p=%b want v=1 y=%h z=%b p=%b",
                         i, out_valid8, out_y8, out_zero8, out_parity8, vy[i], vz[i], vp[i]);
            end
            step();
            n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL func_pop%0d got v=%b want 0", i, out_valid8); end
        end
    endtask

    task automatic test_backpressure();
        out_ready8 = 1'b0;
        in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sel8 = 1'b0;
        step();
        n_cmp++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b1 || out_y8 !== 8'hFF) begin n_err++; $display("FAIL bp_first got r=%b v=%b y=%h want r=1 v=1 y=ff", in_ready8, out_valid8, out_y8); end
        a8 = 8'h0F; b8 = 8'h0F; sel8 = 1'b1;
        step();
        n_cmp++; if (in_ready8 !== 1'b0 || out_y8 !== 8'hFF || out_parity8 !== 1'b0) begin n_err++; $display("FAIL bp_full got r=%b y=%h p=%b want r=0 y=ff p=0", in_ready8, out_y8, out_parity8); end
        a8 = 8'h00; b8 = 8'h00; sel8 = 1'b0;
        step();
        n_cmp++; if (in_ready8 !== 1'b0 || out_y8 !== 8'hFF) begin n_err++; $display("FAIL bp_ignored got r=%b y=%h want r=0 y=ff", in_ready8, out_y8); end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        step();
        n_cmp++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b1 || out_y8 !== 8'h0F) begin n_err++; $display("FAIL bp_second got r=%b v=%b y=%h want r=1 v=1 y=0f", in_ready8, out_valid8, out_y8); end
        step();
        n_cmp++; if (out_valid8 !== 1'b0 || out_y8 !== 8'h0F) begin n_err++; $display("FAIL bp_empty_hold got v=%b y=%h want v=0 y=0f", out_valid8, out_y8); end
        step();
        n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL bp_no_third got v=%b want 0", out_valid8); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [4], vb [4], vy [4];
        logic       vs [4];
        va[0] = 8'h11; vb[0] = 8'h22; vs[0] = 1'b0; vy[0] = 8'h33;
        va[1] = 8'hFF; vb[1] = 8'h0F; vs[1] = 1'b1; vy[1] = 8'h0F;
        va[2] = 8'h80; vb[2] = 8'h00; vs[2] = 1'b0; vy[2] = 8'h80;
        va[3] = 8'hA5; vb[3] = 8'h5A; vs[3] = 1'b0; vy[3] = 8'hFF;
        out_ready8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid8 = 1'b1; a8 = va[i]; b8 = vb[i]; sel8 = vs[i];
            step();
            n_cmp++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b1 || out_y8 !== vy[i]) begin
                n_err++;
                $display("FAIL b2b_%0d got v=%b r=%b y=%h want v=1 r=1 y=%h", i, out_valid8, in_ready8, out_y8, vy[i]);
            end
        end
        in_valid8 = 1'b0;
        step();
        n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL b2b_drain got v=%b want 0", out_valid8); end
    endtask

    task automatic test_reset_mid();
        out_ready8 = 1'b0;
        in_valid8 = 1'b1; a8 = 8'h01; b8 = 8'h02; sel8 = 1'b0;
        step();
        a8 = 8'h04; b8 = 8'h08;
        step();
        n_cmp++; if (in_ready8 !== 1'b0 || out_y8 !== 8'h03) begin n_err++; $display("FAIL rm_full got r=%b y=%h want r=0 y=03", in_ready8, out_y8); end
        out_ready8 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; sel8 = 1'b1;
        rst_n = 1'b0;
        step();
        n_cmp++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || out_y8 !== 8'h00 || out_zero8 !== 1'b1 || out_parity8 !== 1'b0) begin
            n_err++;
            $display("FAIL rm_reset got v=%b r=%b y=%h z=%b p=%b want v=0 r=1 y=00 z=1 p=0",
                     out_valid8, in_ready8, out_y8, out_zero8, out_parity8);
        end
        rst_n = 1'b1;
        a8 = 8'h12; b8 = 8'h10; sel8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        n_cmp++; if (out_valid8 !== 1'b1 || out_y8 !== 8'h10 || out_parity8 !== 1'b1 || out_zero8 !== 1'b0) begin n_err++; $display("FAIL rm_after got v=%b y=%h p=%b z=%b want v=1 y=10 p=1 z=0", out_valid8, out_y8, out_parity8, out_zero8); end
        step();
        n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL rm_drain got v=%b want 0", out_valid8); end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_functions();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
